// File: rtl/aes_dec_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_dec_stream
// Byte-stream wrapper around an external fixed-latency AES-128 decrypt core.
// Collects 16 ciphertext bytes into a block and hands it to the core. It then
// captures the plaintext exactly LATENCY cycles later and streams it out a
// byte at a time, most significant byte first.
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   iKeyLoad      : one-cycle strobe, latches iKeyIn and restarts key warm-up
//   iKeyIn        : new 128-bit key
//   oKey          : registered key to the core
//   oKeyReady     : high once the key has been stable for WARMUP cycles
//   iInData/iInValid/oInReady   : ciphertext byte stream (valid/ready)
//   oCiphertext   : registered block to the core
//   iPlaintext    : plaintext from the core
//   oOutData/oOutValid/iOutReady: plaintext byte stream (valid/ready)
// -----------------------------------------------------------------------------
module aes_dec_stream #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned WARMUP  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iKeyLoad,
  input  logic [127:0] iKeyIn,
  output logic [127:0] oKey,
  output logic         oKeyReady,
  input  logic [7:0]   iInData,
  input  logic         iInValid,
  output logic         oInReady,
  output logic [127:0] oCiphertext,
  input  logic [127:0] iPlaintext,
  output logic [7:0]   oOutData,
  output logic         oOutValid,
  input  logic         iOutReady
);

  localparam int WCW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_NOKEY  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  state_e             state_q;
  logic [WCW-1:0]     wcnt_q;
  logic [127:0]       key_q;
  logic [127:0]       asm_q;
  logic [3:0]         bcnt_q;
  logic               pending_q;
  logic [127:0]       ct_q;
  logic [LATENCY-1:0] tag_q;
  logic [127:0]       buf_q;
  logic               full_q;
  logic [3:0]         k_q;

  logic         in_ready;
  logic         accept;
  logic         last_byte;
  logic         in_flight;
  logic         issue;
  logic         capture;
  logic         out_hs;
  logic [127:0] asm_d;
  logic [6:0]   out_sel;

  assign in_ready  = (state_q == S_RUN) & ~pending_q;
  assign accept    = iInValid & in_ready;
  assign last_byte = accept & (bcnt_q == 4'd15);
  assign asm_d     = {asm_q[119:0], iInData};
  assign in_flight = |tag_q;
  // A block can go out the same cycle its last byte arrives; a key load aborts it.
  assign issue     = (pending_q | last_byte) & ~in_flight & ~full_q & ~iKeyLoad;
  assign capture   = tag_q[LATENCY-1];
  assign out_hs    = full_q & iOutReady;
  // Byte k sits at bit 8*(15-k); for a 4-bit k, 15-k is simply ~k.
  assign out_sel   = {~k_q, 3'b000};

  // Key FSM: key load from any state restarts warm-up; RUN after WARMUP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NOKEY;
      wcnt_q  <= '0;
      key_q   <= 128'd0;
    end else if (iKeyLoad) begin
      state_q <= S_WARMUP;
      wcnt_q  <= '0;
      key_q   <= iKeyIn;
    end else begin
      case (state_q)
        S_WARMUP: begin
          if (wcnt_q == WCW'(WARMUP - 1)) begin
            state_q <= S_RUN;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end
        S_NOKEY: state_q <= S_NOKEY;
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_NOKEY;
      endcase
    end
  end

  // Datapath: byte assembly, issue, latency tag pipe and output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= 128'd0;
      bcnt_q    <= 4'd0;
      pending_q <= 1'b0;
      ct_q      <= 128'd0;
      tag_q     <= '0;
      buf_q     <= 128'd0;
      full_q    <= 1'b0;
      k_q       <= 4'd0;
    end else if (iKeyLoad) begin
      // Abort: drop partial block, in-flight block and undrained output.
      bcnt_q    <= 4'd0;
      pending_q <= 1'b0;
      tag_q     <= '0;
      full_q    <= 1'b0;
      k_q       <= 4'd0;
    end else begin
      if (accept) begin
        asm_q  <= asm_d;
        bcnt_q <= bcnt_q + 4'd1;
      end
      pending_q <= (pending_q | last_byte) & ~issue;
      if (issue) begin
        // No byte can be accepted while pending, so asm_q is complete then.
        ct_q <= pending_q ? asm_q : asm_d;
      end
      tag_q <= (tag_q << 1) | LATENCY'(issue);
      if (capture) begin
        buf_q  <= iPlaintext;
        full_q <= 1'b1;
        k_q    <= 4'd0;
      end else if (out_hs) begin
        k_q <= k_q + 4'd1;
        if (k_q == 4'd15) begin
          full_q <= 1'b0;
        end
      end
    end
  end

  assign oKey        = key_q;
  assign oKeyReady   = (state_q == S_RUN);
  assign oInReady    = in_ready;
  assign oCiphertext = ct_q;
  assign oOutValid   = full_q;
  assign oOutData    = buf_q[out_sel +: 8];

endmodule

// File: tb/tb_aes_dec_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_dec_stream
// Directed bench with an expected-byte queue and an independent output monitor.
// A behavioural decrypt core returns the FIPS-197 plaintext for the FIPS
// key/ciphertext pair and ct ^ key otherwise, delayed by the core latency.
// -----------------------------------------------------------------------------
module tb_aes_dec_stream;

  localparam int LAT = 10;
  localparam int WU  = 10;

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst_n;
  logic         iKeyLoad;
  logic [127:0] iKeyIn;
  logic [127:0] oKey;
  logic         oKeyReady;
  logic [7:0]   iInData;
  logic         iInValid;
  logic         oInReady;
  logic [127:0] oCiphertext;
  logic [127:0] iPlaintext;
  logic [7:0]   oOutData;
  logic         oOutValid;
  logic         iOutReady;

  int checks = 0;
  int errors = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] core_pipe [0:LAT-2];

  aes_dec_stream #(.LATENCY(LAT), .WARMUP(WU)) dut (
    .clk(clk), .rst_n(rst_n), .iKeyLoad(iKeyLoad), .iKeyIn(iKeyIn),
    .oKey(oKey), .oKeyReady(oKeyReady), .iInData(iInData), .iInValid(iInValid),
    .oInReady(oInReady), .oCiphertext(oCiphertext), .iPlaintext(iPlaintext),
    .oOutData(oOutData), .oOutValid(oOutValid), .iOutReady(iOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] core_dec(input logic [127:0] ct, input logic [127:0] key);
    if (key == FK && ct == FCT) return FPT;
    return ct ^ key;
  endfunction

  // Core model: samples the block on the edge after issue, result ready LAT edges after issue.
  always @(posedge clk) begin
    core_pipe[0] <= core_dec(oCiphertext, oKey);
    for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign iPlaintext = core_pipe[LAT-2];

  // Monitor: compares every output handshake against the expected queue.
  always @(negedge clk) begin
    if (rst_n && oOutValid && iOutReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got %h want none", oOutData);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (oOutData !== e) begin
          errors++;
          $display("FAIL out_byte got %h want %h", oOutData, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] pt);
    for (int i = 0; i < 16; i++) exp_q.push_back(pt[127-8*i -: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    iInValid = 1'b1;
    iInData  = b;
    while (!oInReady && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    tick();
    iInValid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] ct, input int nb);
    for (int i = 0; i < nb; i++) send_byte(ct[127-8*i -: 8]);
  endtask

  task automatic load_key(input logic [127:0] k);
    iKeyLoad = 1'b1;
    iKeyIn   = k;
    tick();
    iKeyLoad = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int  cnt;
    logic ok;
    rst_n = 1'b0; iKeyLoad = 1'b0; iKeyIn = 128'd0; iInData = 8'd0;
    iInValid = 1'b0; iOutReady = 1'b1;
    #12;
    // Reset state
    check("rst_oKey",        oKey,        128'd0);
    check("rst_oKeyReady",   128'(oKeyReady), 128'd0);
    check("rst_oInReady",    128'(oInReady),  128'd0);
    check("rst_oOutValid",   128'(oOutValid), 128'd0);
    check("rst_oOutData",    128'(oOutData),  128'd0);
    check("rst_oCiphertext", oCiphertext, 128'd0);
    #5 rst_n = 1'b1;
    tick();

    // Warm-up with input held valid
    iInValid = 1'b1; iInData = 8'h69;
    load_key(FK);
    iInValid = 1'b1;
    cnt = 0; ok = 1'b1;
    while (!oInReady && cnt < 50) begin
      if (oKeyReady !== oInReady) ok = 1'b0;
      tick();
      cnt++;
    end
    check("warmup_cycles", 128'(cnt), 128'd10);
    check("warmup_keyready_rise", 128'({ok, oKeyReady}), 128'd3);
    check("warmup_oKey", oKey, FK);

    // FIPS-197 block and latency from issue edge
    push_exp(FPT);
    send_bytes(FCT, 16);
    cnt = 0;
    while (!oOutValid && cnt < 100) begin
      tick();
      cnt++;
    end
    check("latency", 128'(cnt), 128'd10);
    check("issue_ct", oCiphertext, FCT);
    wait_drain("drain_fips");
    check("ct_hold", oCiphertext, FCT);

    // Two more patterns back-to-back with free-running output
    push_exp(128'h000102030405060708090a0b0c0d0e0f);
    send_bytes(128'h0, 16);
    push_exp(128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    send_bytes({128{1'b1}}, 16);
    wait_drain("drain_ab");

    // Back-pressure: two blocks, output stalled
    iOutReady = 1'b0;
    push_exp(FPT);
    send_bytes(FCT, 16);
    push_exp(128'hf0e0d0c0b0a090807060504030201000);
    send_bytes(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 16);
    check("bp_in_ready_low", 128'(oInReady), 128'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (oOutValid !== 1'b1 || oOutData !== 8'h00 || oInReady !== 1'b0) ok = 1'b0;
      tick();
    end
    check("bp_hold", 128'(ok), 128'd1);
    iOutReady = 1'b1;
    wait_drain("drain_bp");

    // Key reload after 7 bytes of a block
    send_bytes(128'h112233445566778899aabbccddeeff00, 7);
    load_key(K2);
    check("reload_oKey", oKey, K2);
    push_exp(128'hd481eae9d7512d59abf7158809cf4f3c);
    send_bytes(128'hffffffffffffffff0000000000000000, 16);
    wait_drain("drain_k2");

    // Key reload with a block in flight
    send_bytes(128'h0123456789abcdef0123456789abcdef, 16);
    load_key(FK);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (oOutValid !== 1'b0) ok = 1'b0;
      tick();
    end
    check("abort_no_output", 128'(ok), 128'd1);
    push_exp(FPT);
    send_bytes(FCT, 16);
    wait_drain("drain_after_abort");

    // Reset while output byte k=5 is presented
    iOutReady = 1'b0;
    push_exp(128'h000102030405060708090a0b0c0d0e0f);
    send_bytes(128'h0, 16);
    cnt = 0;
    while (!oOutValid && cnt < 100) begin
      tick();
      cnt++;
    end
    iOutReady = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    iOutReady = 1'b0;
    check("pre_rst_byte5", 128'(oOutData), 128'h05);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_oOutValid", 128'(oOutValid), 128'd0);
    check("rst_mid_oKeyReady", 128'(oKeyReady), 128'd0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    iOutReady = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oKeyReady !== 1'b0 || oInReady !== 1'b0 || oOutValid !== 1'b0) ok = 1'b0;
    end
    check("post_rst_idle", 128'(ok), 128'd1);
    check("post_rst_oKey", oKey, 128'd0);

    // Fresh key after reset
    load_key(FK);
    push_exp(FPT);
    send_bytes(FCT, 16);
    wait_drain("drain_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_stream.md
AES_DEC_STREAM -- requirements
Module: aes_dec_stream

Interface
REQ-001 SHALL have parameter LATENCY, default 10, giving the decrypt core cycles from ciphertext-sampled edge to plaintext valid.
REQ-002 SHALL have parameter WARMUP, default 10, giving the cycles the key must be stable before the first block issues.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iKeyLoad  input  1  one-cycle key-load strobe.
REQ-006 SHALL have port iKeyIn  input  128  new key, sampled when iKeyLoad=1.
REQ-007 SHALL have port oKey  output  128  registered key driven to the core iKey.
REQ-008 SHALL have port oKeyReady  output  1  high in RUN state only.
REQ-009 SHALL have port iInData  input  8  ciphertext byte.
REQ-010 SHALL have port iInValid  input  1  input byte valid.
REQ-011 SHALL have port oInReady  output  1  input byte accepted when iInValid&oInReady.
REQ-012 SHALL have port oCiphertext  output  128  registered block driven to the core iCiphertext.
REQ-013 SHALL have port iPlaintext  input  128  core oPlaintext.
REQ-014 SHALL have port oOutData  output  8  plaintext byte.
REQ-015 SHALL have port oOutValid  output  1  output byte valid.
REQ-016 SHALL have port iOutReady  input  1  output byte consumed when oOutValid&iOutReady.

Function
REQ-017 SHALL implement states NOKEY, WARMUP and RUN: iKeyLoad from any state latches oKey and enters WARMUP with a warm-up counter cleared to 0.
REQ-018 SHALL stay in WARMUP, counting up, and move to RUN on the cycle the counter reaches WARMUP-1.
REQ-019 SHALL make an iKeyLoad in WARMUP or RUN abort the current operation: byte count, in-flight tag pipe, pending block and output buffer all clear in the same cycle.
REQ-020 SHALL drive oInReady = (state==RUN) & ~pending.
REQ-021 SHALL shift each accepted byte into an assembly register, so the first byte of a block lands in bits [127:120].
REQ-022 SHALL use a 4-bit byte counter that wraps 15->0 on the 16th byte and sets pending.
REQ-023 SHALL issue a pending block only when no block is in flight and the output buffer is empty; on issue, oCiphertext loads the assembly register and a valid tag enters a LATENCY-bit shift pipe.
REQ-024 SHALL allow issue in the same cycle as the 16th byte is accepted if the issue conditions hold.
REQ-025 SHALL keep oCiphertext unchanged except at issue.
REQ-026 SHALL capture iPlaintext into the 128-bit output buffer and set buffer-full on the cycle the tag exits the pipe, exactly LATENCY cycles after the issue edge.
REQ-027 SHALL drive oOutValid = buffer-full and oOutData = buffer[127-8*k -: 8], where k is the 4-bit output index.
REQ-028 SHALL advance k on each output handshake; the handshake at k=15 clears buffer-full and sets k to 0.
REQ-029 SHALL hold oOutData and oOutValid stable while oOutValid=1 and iOutReady=0.
REQ-030 SHALL allow assembly of the next block while the current block is in flight or draining; only issue waits.
REQ-031 SHALL ignore iInValid while oInReady=0; no byte is lost or duplicated.

Reset
REQ-032 SHALL, on rst_n=0, immediately clear state to NOKEY and clear every counter, the tag pipe, pending and buffer-full.
REQ-033 SHALL, under reset, drive oKey, oCiphertext and oOutData to 0 and oKeyReady, oInReady and oOutValid to 0.
REQ-034 SHALL behave after reset release as if no key had been loaded; blocks are accepted only after a fresh iKeyLoad and WARMUP cycles.

Verification
REQ-035 SHALL cover FIPS-197 decryption: key 000102030405060708090a0b0c0d0e0f, bytes 69,c4,e0,d8,6a,7b,04,30,d8,cd,b7,80,70,b4,c5,5a -> out bytes 00,11,22,...,ee,ff in order.
REQ-036 SHALL cover warm-up: iKeyLoad then input held valid -> oInReady=0 for exactly 10 cycles; oKeyReady rises on the same cycle oInReady rises.
REQ-037 SHALL cover latency: issue at edge N -> oOutValid=1 first at edge N+10 with iOutReady=1.
REQ-038 SHALL cover back-pressure: two blocks back-to-back with iOutReady=0 for 50 cycles -> first block held with oOutData=00; after the 16th byte of block 2 oInReady=0 until block 1 drains; both blocks then emerge intact.
REQ-039 SHALL cover mid-operation key reload: iKeyLoad after 7 input bytes, or with a block in flight -> no output appears from the aborted block and the next 16 bytes decrypt under the new key.
REQ-040 SHALL cover reset mid-output: rst_n=0 at output byte k=5 -> oOutValid=0 immediately and oKeyReady=0 after release.
